// File: rtl/ahb_multiplexor_n.sv
// ---------------------------------------------------------------------------
// ahb_multiplexor_n
// AHB-Lite address decoder and response multiplexor for one controller and
// NUM_SAT satellites. The controller's address and control signals go to
// every satellite unchanged. An address decode drives a one-hot select. A
// data-phase FSM then returns the chosen satellite's ready/response/read data
// to the controller. The FSM produces a two-cycle ERROR response for an
// unmapped access and for a satellite that stalls too long.
//
// Ports:
//   clk, nrst        clock, synchronous active-low reset
//   m_haddr..m_hwdata controller address/control/write data (inputs)
//   m_hready/m_hresp/m_hrdata  response to controller
//   s_hsel           one-hot satellite select (combinational decode)
//   s_haddr..s_hwdata controller signals passed to all satellites
//   s_hready         passed to all satellites, equals m_hready
//   s_hreadyout/s_hresp/s_hrdata  per-satellite responses
//   err_unmapped     one-cycle pulse in the first ERROR cycle of an unmapped access
//   err_timeout      one-cycle pulse in the first ERROR cycle of a stall timeout
// ---------------------------------------------------------------------------
module ahb_multiplexor_n #(
   parameter int                      NUM_SAT        = 3,
   parameter logic [NUM_SAT*32-1:0]   BASE_ADDR      = {32'h2004_0000, 32'h2002_0000, 32'h0000_0000},
   parameter logic [NUM_SAT*32-1:0]   ADDR_MASK      = {32'hFFFF_F800, 32'hFFFF_FFF0, 32'hFFF0_0000},
   parameter int                      TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [31:0]             m_haddr,
   input  logic [1:0]              m_htrans,
   input  logic                    m_hwrite,
   input  logic [2:0]              m_hsize,
   input  logic [2:0]              m_hburst,
   input  logic [31:0]             m_hwdata,
   output logic                    m_hready,
   output logic                    m_hresp,
   output logic [31:0]             m_hrdata,
   output logic [NUM_SAT-1:0]      s_hsel,
   output logic [31:0]             s_haddr,
   output logic [1:0]              s_htrans,
   output logic                    s_hwrite,
   output logic [2:0]              s_hsize,
   output logic [2:0]              s_hburst,
   output logic [31:0]             s_hwdata,
   output logic                    s_hready,
   input  logic [NUM_SAT-1:0]      s_hreadyout,
   input  logic [NUM_SAT-1:0]      s_hresp,
   input  logic [NUM_SAT*32-1:0]   s_hrdata,
   output logic                    err_unmapped,
   output logic                    err_timeout
);

   localparam int SEL_W = (NUM_SAT > 1) ? $clog2(NUM_SAT) : 1;
   // A zero timeout still needs a legal counter width; the counter is unused then.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SAT, ERR1, ERR2} state_t;

   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic [CNT_W-1:0]   stall_cnt;
   logic               addr_hit;
   logic [SEL_W-1:0]   hit_idx;
   logic               sel_ready;
   logic               sel_resp;
   logic [31:0]        sel_rdata;
   logic               timeout_hit;

   assign s_haddr  = m_haddr;
   assign s_htrans = m_htrans;
   assign s_hwrite = m_hwrite;
   assign s_hsize  = m_hsize;
   assign s_hburst = m_hburst;
   assign s_hwdata = m_hwdata;
   assign s_hready = m_hready;

   // The decode scans from the highest index down. When several satellites
   // match, the lowest-index match is written last and wins.
   always_comb begin
      addr_hit = 1'b0;
      hit_idx  = '0;
      for (int i = NUM_SAT - 1; i >= 0; i--) begin
         if ((m_haddr & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32]) begin
            addr_hit = 1'b1;
            hit_idx  = SEL_W'(i);
         end
      end
   end

   always_comb begin
      s_hsel = '0;
      if (addr_hit) s_hsel[hit_idx] = 1'b1;
   end

   assign sel_ready = s_hreadyout[sel_q];
   assign sel_resp  = s_hresp[sel_q];
   assign sel_rdata = s_hrdata[sel_q*32 +: 32];

   // The controller-facing response depends only on the registered data-phase
   // state and the satellite inputs. It never looks at the current address phase.
   always_comb begin
      m_hready = 1'b1;
      m_hresp  = 1'b0;
      m_hrdata = '0;
      case (state)
         SAT: begin
            m_hready = sel_ready;
            m_hresp  = sel_resp;
            m_hrdata = sel_rdata;
         end
         ERR1: begin
            m_hready = 1'b0;
            m_hresp  = 1'b1;
         end
         ERR2: begin
            m_hresp  = 1'b1;
         end
         default: ;
      endcase
   end

   // When stall_cnt equals TIMEOUT_CYCLES-1 during a stalled cycle, that cycle
   // is the TIMEOUT_CYCLES-th consecutive stall.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Data-phase FSM. A new address phase is accepted whenever m_hready is high.
   // m_hready is low only in ERR1 and in a stalled SAT cycle, so the final
   // branch handles the stalled satellite.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= IDLE;
         sel_q        <= '0;
         stall_cnt    <= '0;
         err_unmapped <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         err_unmapped <= 1'b0;
         err_timeout  <= 1'b0;
         if (state == ERR1) begin
            state     <= ERR2;
            stall_cnt <= '0;
         end else if (m_hready) begin
            stall_cnt <= '0;
            if (m_htrans[1]) begin
               if (addr_hit) begin
                  state <= SAT;
                  sel_q <= hit_idx;
               end else begin
                  state        <= ERR1;
                  err_unmapped <= 1'b1;
               end
            end else begin
               state <= IDLE;
            end
         end else if (timeout_hit) begin
            state       <= ERR1;
            stall_cnt   <= '0;
            err_timeout <= 1'b1;
         end else begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_multiplexor_n.sv
// ---------------------------------------------------------------------------
// tb_ahb_multiplexor_n
// Directed bench for ahb_multiplexor_n with TIMEOUT_CYCLES=4 and the default
// satellite map. A transaction-level model tracks the outstanding data phase.
// On every negative clock edge the model's expected outputs are compared with
// the DUT. Hand-computed literal checks in the stimulus sequence pin the model.
// ---------------------------------------------------------------------------
module tb_ahb_multiplexor_n;

   localparam int NSAT = 3;
   localparam int TMO  = 4;
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [31:0] m_haddr = '0;
   logic [1:0]  m_htrans = T_IDLE;
   logic        m_hwrite = 1'b0;
   logic [2:0]  m_hsize = 3'b010;
   logic [2:0]  m_hburst = 3'b000;
   logic [31:0] m_hwdata = '0;
   logic        m_hready, m_hresp;
   logic [31:0] m_hrdata;
   logic [NSAT-1:0] s_hsel;
   logic [31:0] s_haddr, s_hwdata;
   logic [1:0]  s_htrans;
   logic        s_hwrite, s_hready;
   logic [2:0]  s_hsize, s_hburst;
   logic [NSAT-1:0] s_hreadyout = '1;
   logic [NSAT-1:0] s_hresp = '0;
   logic [NSAT*32-1:0] s_hrdata = {32'hB2B2_0002, 32'hA5A5_0001, 32'h0000_00C0};
   logic        err_unmapped, err_timeout;

   int testsRun = 0;
   int testsFailed = 0;
   bit modelOn = 1'b0;

   // Satellite memory map, written as a plain lookup table.
   logic [31:0] satBase [NSAT] = '{32'h0000_0000, 32'h2002_0000, 32'h2004_0000};
   logic [31:0] satMask [NSAT] = '{32'hFFF0_0000, 32'hFFFF_FFF0, 32'hFFFF_F800};

   // Model state: the satellite that owns the pending data phase (-1 for none),
   // the error-response step (0 none, 1 first cycle, 2 second cycle), the cause
   // of the error, and the number of consecutive stalls so far.
   int pendSat = -1;
   int errStep = 0;
   bit errByTimeout = 1'b0;
   int stalls = 0;

   always #5 clk = ~clk;

   ahb_multiplexor_n #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .nrst(nrst),
      .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
      .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
      .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
      .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
      .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hwdata(s_hwdata), .s_hready(s_hready),
      .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
      .err_unmapped(err_unmapped), .err_timeout(err_timeout)
   );

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NSAT; i++)
         if ((a & satMask[i]) == satBase[i]) return i;
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of controller and satellite inputs just after the rising
   // edge. The task returns mid-cycle so that literal checks see settled outputs.
   task automatic applyStimulus(input logic rstn, input logic [31:0] addr, input logic [1:0] trans,
                                input logic wr, input logic [2:0] rdy, input logic [2:0] resp);
      @(posedge clk);
      #1;
      nrst        = rstn;
      m_haddr     = addr;
      m_htrans    = trans;
      m_hwrite    = wr;
      m_hwdata    = addr ^ 32'h5A5A_5A5A;
      s_hreadyout = rdy;
      s_hresp     = resp;
      #2;
   endtask

   // Per-cycle comparison against the model, followed by the model advancing
   // on the inputs that the next rising edge will sample.
   always @(negedge clk) begin
      logic        expRdy, expResp;
      logic [31:0] expData;
      logic [NSAT-1:0] expSel;
      int d;
      if (modelOn) begin
         expRdy = 1'b1; expResp = 1'b0; expData = '0;
         if (errStep == 1) begin
            expRdy = 1'b0; expResp = 1'b1;
         end else if (errStep == 2) begin
            expResp = 1'b1;
         end else if (pendSat >= 0) begin
            expRdy  = s_hreadyout[pendSat];
            expResp = s_hresp[pendSat];
            expData = s_hrdata[pendSat*32 +: 32];
         end
         d = decode(m_haddr);
         expSel = '0;
         if (d >= 0) expSel[d] = 1'b1;
         checkOutput("m_hready", 32'(m_hready), 32'(expRdy));
         checkOutput("m_hresp", 32'(m_hresp), 32'(expResp));
         checkOutput("m_hrdata", m_hrdata, expData);
         checkOutput("s_hsel", 32'(s_hsel), 32'(expSel));
         checkOutput("s_hready", 32'(s_hready), 32'(expRdy));
         checkOutput("s_haddr", s_haddr, m_haddr ^ 32'h0);
         checkOutput("s_hwdata", s_hwdata, m_hwdata);
         checkOutput("err_unmapped", 32'(err_unmapped), 32'(errStep == 1 && !errByTimeout));
         checkOutput("err_timeout", 32'(err_timeout), 32'(errStep == 1 && errByTimeout));

         if (!nrst) begin
            pendSat = -1; errStep = 0; stalls = 0;
         end else if (errStep == 1) begin
            errStep = 2;
         end else if (expRdy) begin
            errStep = 0; stalls = 0; pendSat = -1;
            if (m_htrans[1]) begin
               if (d < 0) begin
                  errStep = 1; errByTimeout = 1'b0;
               end else begin
                  pendSat = d;
               end
            end
         end else begin
            stalls++;
            if (stalls == TMO) begin
               errStep = 1; errByTimeout = 1'b1; pendSat = -1; stalls = 0;
            end
         end
      end
   end

   initial begin
      // Reset, then the idle response
      applyStimulus(1'b0, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      modelOn = 1'b1;
      applyStimulus(1'b0, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("reset_hready", 32'(m_hready), 32'd1);
      checkOutput("reset_hresp", 32'(m_hresp), 32'd0);
      checkOutput("reset_hrdata", m_hrdata, 32'd0);

      // Zero-wait read from satellite 1
      applyStimulus(1'b1, 32'h2002_0004, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      checkOutput("read_hsel", 32'(s_hsel), 32'b010);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("read_hrdata", m_hrdata, 32'hA5A5_0001);
      checkOutput("read_hready", 32'(m_hready), 32'd1);
      checkOutput("read_hresp", 32'(m_hresp), 32'd0);

      // A BUSY transfer to a mapped address gets no data phase
      applyStimulus(1'b1, 32'h2002_0000, T_BUSY, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("busy_hrdata", m_hrdata, 32'd0);

      // Unmapped access: two-cycle ERROR response
      applyStimulus(1'b1, 32'h3000_0000, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      checkOutput("unmap_hsel", 32'(s_hsel), 32'd0);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("unmap_err1_hready", 32'(m_hready), 32'd0);
      checkOutput("unmap_err1_hresp", 32'(m_hresp), 32'd1);
      checkOutput("unmap_err1_pulse", 32'(err_unmapped), 32'd1);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("unmap_err2_hready", 32'(m_hready), 32'd1);
      checkOutput("unmap_err2_hresp", 32'(m_hresp), 32'd1);
      checkOutput("unmap_err2_pulse", 32'(err_unmapped), 32'd0);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("unmap_after_hresp", 32'(m_hresp), 32'd0);

      // Write to satellite 2, which stalls for three cycles
      applyStimulus(1'b1, 32'h2004_0010, T_NONSEQ, 1'b1, 3'b111, 3'b000);
      checkOutput("stall_hsel", 32'(s_hsel), 32'b100);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b011, 3'b000);
         checkOutput("stall_hready", 32'(m_hready), 32'd0);
      end
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("stall_done_hready", 32'(m_hready), 32'd1);
      checkOutput("stall_done_timeout", 32'(err_timeout), 32'd0);

      // Satellite 0 stalls indefinitely; timeout after 4 stalled cycles
      applyStimulus(1'b1, 32'h0000_0100, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      for (int i = 0; i < TMO; i++) begin
         applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b110, 3'b000);
         checkOutput("tmo_stall_hready", 32'(m_hready), 32'd0);
         checkOutput("tmo_stall_hresp", 32'(m_hresp), 32'd0);
      end
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b110, 3'b000);
      checkOutput("tmo_err1_hresp", 32'(m_hresp), 32'd1);
      checkOutput("tmo_err1_pulse", 32'(err_timeout), 32'd1);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b110, 3'b000);
      checkOutput("tmo_err2_hready", 32'(m_hready), 32'd1);
      checkOutput("tmo_err2_pulse", 32'(err_timeout), 32'd0);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("tmo_after_hresp", 32'(m_hresp), 32'd0);

      // Satellite-originated ERROR is forwarded without a pulse
      applyStimulus(1'b1, 32'h2002_0000, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b010);
      checkOutput("sat_err_hresp", 32'(m_hresp), 32'd1);
      checkOutput("sat_err_pulse", 32'({err_unmapped, err_timeout}), 32'd0);

      // Back-to-back reads with a source switch, then an IDLE to an unmapped address
      applyStimulus(1'b1, 32'h2002_0008, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b1, 32'h2004_0000, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      checkOutput("b2b_first_hrdata", m_hrdata, 32'hA5A5_0001);
      applyStimulus(1'b1, 32'h3000_0000, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("b2b_second_hrdata", m_hrdata, 32'hB2B2_0002);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("idle_unmapped_hresp", 32'(m_hresp), 32'd0);
      checkOutput("idle_unmapped_pulse", 32'(err_unmapped), 32'd0);

      // Reset in the middle of a stall
      applyStimulus(1'b1, 32'h2004_0020, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b0, 32'h0, T_IDLE, 1'b0, 3'b011, 3'b000);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b011, 3'b000);
      checkOutput("stall_reset_hready", 32'(m_hready), 32'd1);

      // Reset during ERR1
      applyStimulus(1'b1, 32'h3000_0000, T_NONSEQ, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b0, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("err1_reset_in_err1", 32'(err_unmapped), 32'd1);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      checkOutput("err1_reset_hready", 32'(m_hready), 32'd1);
      checkOutput("err1_reset_hresp", 32'(m_hresp), 32'd0);
      checkOutput("err1_reset_pulses", 32'({err_unmapped, err_timeout}), 32'd0);

      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      applyStimulus(1'b1, 32'h0, T_IDLE, 1'b0, 3'b111, 3'b000);
      modelOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ahb_multiplexor_n.md
AHB_MULTIPLEXOR_N -- requirements
Module: ahb_multiplexor_n

Interface
Parameters:
REQ-001 SHALL provide parameter NUM_SAT, default 3, number of satellite ports (legal range 1..8).
REQ-002 SHALL provide parameter BASE_ADDR, default {32'h2004_0000, 32'h2002_0000, 32'h0000_0000}, packed NUM_SAT*32, base address of satellite i at bits [32i+31:32i].
REQ-003 SHALL provide parameter ADDR_MASK, default {32'hFFFF_F800, 32'hFFFF_FFF0, 32'hFFF0_0000}, packed NUM_SAT*32, compare mask of satellite i.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 255, data-phase stall limit; 0 disables the timeout.

Ports:
REQ-005 SHALL provide ports:
- clk  in  1  clock; all state updates on its rising edge.
- nrst  in  1  synchronous, active-low reset.
- m_haddr  in  32  controller address.
- m_htrans  in  2  controller transfer type.
- m_hwrite, m_hsize[3], m_hburst[3], m_hwdata[32]  in  controller control and write data.
- m_hready  out  1  transfer-complete to controller.
- m_hresp  out  1  response to controller (0 OKAY, 1 ERROR).
- m_hrdata  out  32  read data to controller.
- s_hsel  out  NUM_SAT  per-satellite select.
- s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata  out  controller signals broadcast unchanged to all satellites.
- s_hready  out  1  broadcast; equals m_hready.
- s_hreadyout  in  NUM_SAT  per-satellite ready.
- s_hresp  in  NUM_SAT  per-satellite response.
- s_hrdata  in  NUM_SAT*32  per-satellite read data.
- err_unmapped  out  1  one-cycle pulse on an unmapped-access error.
- err_timeout  out  1  one-cycle pulse on a timeout error.

Function
REQ-006 SHALL flag satellite i as matching when (m_haddr & ADDR_MASK[i]) == BASE_ADDR[i]; on multiple matches the lowest index wins.
REQ-007 SHALL drive s_hsel combinationally, one-hot at the winning index or all zero; it does not depend on m_htrans.
REQ-008 SHALL run a data-phase FSM with states IDLE, SAT, ERR1 and ERR2, plus a registered index sel_q.
REQ-009 SHALL sample the address phase on any cycle where m_hready=1, and go to the next state as follows:
- m_htrans NONSEQ or SEQ with a match: go to SAT and sel_q <= winning index.
- m_htrans NONSEQ or SEQ with no match: go to ERR1 (unmapped).
- m_htrans IDLE or BUSY: go to IDLE.
REQ-010 In IDLE the block SHALL drive m_hready=1, m_hresp=0 and m_hrdata=0 (zero-wait OKAY).
REQ-011 In SAT the block SHALL drive m_hready, m_hresp and m_hrdata from s_hreadyout[sel_q], s_hresp[sel_q] and s_hrdata[sel_q].
REQ-012 ERR1 SHALL drive m_hready=0, m_hresp=1 and m_hrdata=0, then go to ERR2 unconditionally.
REQ-013 ERR2 SHALL drive m_hready=1, m_hresp=1 and m_hrdata=0; this is the AHB two-cycle ERROR response, and the next address phase is sampled per REQ-009.
REQ-014 SHALL keep a stall counter, width clog2(TIMEOUT_CYCLES+1):
- increments each SAT cycle with s_hreadyout[sel_q]=0;
- clears when m_hready=1 and on leaving SAT.
REQ-015 When TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 in a stalled SAT cycle, the FSM SHALL go to ERR1 (timeout), abandoning the satellite's data phase.
- The TIMEOUT_CYCLES-th consecutive stalled SAT cycle is therefore followed by ERR1.
- A satellite that still reports a stall in ERR1/ERR2 is ignored.
REQ-016 err_unmapped SHALL pulse high for exactly the first cycle of ERR1 when it was entered from an unmapped access; err_timeout likewise when entered by timeout.
REQ-017 A satellite asserting s_hresp=1 SHALL be forwarded unmodified; the block does not generate or count satellite-originated errors.
REQ-018 m_hready, m_hresp and m_hrdata SHALL have no combinational path from m_haddr or m_htrans; they depend only on state, sel_q and satellite inputs.

Reset
REQ-019 When nrst=0 at a rising edge, the block SHALL set state=IDLE, sel_q=0, the counter to 0 and err_unmapped/err_timeout to 0.
- Outputs then read m_hready=1, m_hresp=0, m_hrdata=0.
- This applies even mid-ERR1, mid-ERR2 or mid-stall.
REQ-020 The first address phase after reset release SHALL be sampled on the first edge with nrst=1.

Verification
REQ-021 Read 0x2002_0004 NONSEQ, satellite 1 returns hreadyout=1 with hrdata=0xA5A5_0001 -> s_hsel=3'b010 in the address phase; next cycle m_hrdata=0xA5A5_0001, m_hready=1, m_hresp=0.
REQ-022 NONSEQ to 0x3000_0000 (unmapped) -> cycle+1: m_hready=0, m_hresp=1, err_unmapped=1; cycle+2: m_hready=1, m_hresp=1; cycle+3 with IDLE issued: m_hready=1, m_hresp=0.
REQ-023 Satellite 2 holds hreadyout=0 for 3 cycles on a 0x2004_0010 write -> m_hready=0 for 3 cycles, then 1; no error.
REQ-024 TIMEOUT_CYCLES=4, satellite 0 stalls indefinitely -> 4 cycles with m_hready=0 and m_hresp=0, then ERR1 with err_timeout=1, then ERR2.
REQ-025 Back-to-back NONSEQ to sat1 then sat2 with zero wait -> m_hrdata switches source on consecutive cycles; IDLE to an unmapped address -> OKAY with no error.
REQ-026 nrst=0 asserted during ERR1 -> next cycle m_hready=1, m_hresp=0, err_* pulses=0.
